// File: rtl/neuron_mac.sv
// Multiply-accumulate front end of one neuron: bias plus N_INPUTS activation*weight
// products, arithmetically scaled and saturated to a signed 32-bit pre-activation.
module neuron_mac #(
    parameter int N_INPUTS = 16,
    parameter int SHIFT    = 4,
    parameter int ACC_W    = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] bias,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic [7:0]  in_weight,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_INPUTS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCALE = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                   state_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic [CNT_W-1:0]         cnt_reg;
    logic                     out_valid_reg;
    logic [31:0]              out_data_reg;

    logic signed [16:0]       act_ext;
    logic signed [16:0]       wgt_ext;
    logic signed [16:0]       product;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  shifted;
    logic [ACC_W-32:0]        shifted_top;
    logic                     pos_ovf;
    logic                     neg_ovf;
    logic [31:0]              sat_value;
    logic                     beat_accept;

    // Activation is unsigned, so it gets a zero top bit before the signed multiply.
    assign act_ext = {9'd0, in_data};
    assign wgt_ext = {{9{in_weight[7]}}, in_weight};
    assign product = act_ext * wgt_ext;
    assign acc_sum = acc_reg + ACC_W'(product);

    assign shifted     = acc_reg >>> SHIFT;
    assign shifted_top = shifted[ACC_W-1:31];
    // Fits in 32 bits only when every bit from 31 upward equals the sign bit.
    assign pos_ovf = !shifted[ACC_W-1] && (|shifted_top);
    assign neg_ovf = shifted[ACC_W-1] && !(&shifted_top);

    always_comb begin
        sat_value = shifted[31:0];
        if (pos_ovf) begin
            sat_value = 32'h7FFF_FFFF;
        end else if (neg_ovf) begin
            sat_value = 32'h8000_0000;
        end
    end

    assign in_ready    = (state_reg == ACCUM);
    assign busy        = (state_reg != IDLE);
    assign beat_accept = in_valid && in_ready;
    assign out_valid   = out_valid_reg;
    assign out_data    = out_data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        acc_reg   <= ACC_W'($signed(bias));
                        cnt_reg   <= '0;
                        state_reg <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat_accept) begin
                        acc_reg <= acc_sum;
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg == LAST_BEAT) begin
                            state_reg <= SCALE;
                        end
                    end
                end
                SCALE: begin
                    out_data_reg  <= sat_value;
                    out_valid_reg <= 1'b1;
                    state_reg     <= OUT;
                end
                OUT: begin
                    // start is deliberately not looked at here, forcing an IDLE bubble.
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/neuron_mac.md
Name: neuron_mac

Overview:
- Per-neuron multiply-accumulate stage that sits directly upstream of the sigmoid activation.
- Consumes a stream of N_INPUTS (activation, weight) pairs and accumulates their products onto a bias.
- Scales the sum by an arithmetic right shift and saturates it to 32 bits.
- Presents the signed 32-bit pre-activation value on a valid/ready output that feeds the activation stage's x input.

Parameters:
- N_INPUTS, 16, number of input beats per neuron evaluation (>=1).
- SHIFT, 4, arithmetic right shift applied to the accumulator before output (0..8).
- ACC_W, 40, internal accumulator width in bits (>=32).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin an evaluation; sampled only in IDLE.
- bias  input  32  signed bias; captured when start is accepted.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept an input beat.
- in_data  input  8  unsigned activation, 0..255.
- in_weight  input  8  signed weight, -128..127.
- out_valid  output  1  pre-activation result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  32  signed, saturated, scaled pre-activation.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE; accumulator=0; beat counter=0.
  - in_ready=0, out_valid=0, out_data=0, busy=0. Takes effect immediately, from any state.
- FSM states: IDLE, ACCUM, SCALE, OUT.
- IDLE:
  - start=1 at an edge loads acc with sign-extended bias, clears the counter and moves to ACCUM.
  - bias is irrelevant at all other times.
- start in any state other than IDLE is ignored, with no effect on acc, counter or outputs.
- ACCUM:
  - in_ready=1 (combinational from state).
  - A beat is accepted on an edge where in_valid && in_ready. On accept: acc += sext(product) and the counter increments.
  - product = zero-extended in_data (9-bit signed) × in_weight, giving a 17-bit signed result.
  - in_valid gaps are allowed. Only accepted beats count; there is no timeout.
  - When the N_INPUTS-th beat is accepted, the next state is SCALE. in_ready is 0 from the following cycle.
- SCALE (exactly one cycle):
  - shifted = acc >>> SHIFT (arithmetic, floor toward -inf).
  - If shifted > 2^31-1, out_data = 0x7FFFFFFF.
  - Else if shifted < -2^31, out_data = 0x80000000.
  - Else out_data = shifted[31:0].
  - out_valid is set; next state is OUT.
- Latency: the final input beat is accepted at edge E, and out_valid=1 after edge E+1.
- OUT:
  - out_valid=1; out_data is held stable until the handshake.
  - On an edge with out_ready=1: out_valid clears and the next state is IDLE. out_data keeps its last value.
  - start is ignored in OUT, including a start in the same cycle as the handshake. This gives a minimum one-cycle IDLE bubble between evaluations.
- ACC_W=40 holds N_INPUTS up to 2^7 beats of full-scale products plus the full 32-bit bias without wrap. Accumulator wrap is therefore not a legal operating condition.

Test Plan:
1. Basic, N_INPUTS=4, SHIFT=4: bias=16, data {16,32,48,64}, weights all 1, in_valid held high -> acc=176; out_data=11; out_valid rises one edge after the 4th accept; in_ready low during SCALE/OUT.
2. Negative and floor:
   - bias=0, data 255×4, weight -128 -> out_data=-8160 (0xFFFFE020).
   - Then bias=-1, data 0×4 -> out_data=-1 (floor, not 0).
3. Saturation, SHIFT=0:
   - bias=0x7FFFFFFF, data 255, weight 127 ×4 -> out_data=0x7FFFFFFF.
   - bias=0x80000000, data 255, weight -128 ×4 -> out_data=0x80000000.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid, pulsing start and in_valid meanwhile -> out_valid stays 1, out_data constant, in_ready=0, no new evaluation. Raise out_ready -> out_valid=0 and busy=0 after that edge.
5. Input gaps: repeat scenario 1 with in_valid toggling every other cycle and random values applied while in_valid=0 -> out_data=11; exactly 4 beats consumed.
6. Reset mid-operation: assert rst_n=0 asynchronously after 2 accepted beats -> in_ready, out_valid, busy and out_data go to 0 without waiting for a clock edge. After release, scenario 1 -> out_data=11 with no residue from the aborted run.
